// File: rtl/gpu_endpoint_ni.sv
// rtl/gpu_endpoint_ni.sv - GPU-side network interface with TX/RX FIFOs, paced injection and local loopback
//
// Purpose:
//   Buffers core transmit words and injects them into the leaf router one
//   word per issue slot, throttled by the router's crossbar-busy signal.
//   Captures every word the router delivers into an RX FIFO and counts the
//   words dropped when it is full. Words addressed to this GPU are looped
//   back into the RX FIFO and never enter the network.
//
// Ports:
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   core_tx_data/dest   core word and its 6-bit destination {group, node}
//   core_tx_valid/ready core TX handshake (ready = TX FIFO not full)
//   core_rx_data/valid  RX FIFO head (show-ahead) and not-empty flag
//   core_rx_ready       core pops the RX head
//   net_tx_data/dest    registered word and destination to the router
//   net_tx_valid        high for the single ISSUE cycle
//   net_busy            router crossbar busy; holds off injection
//   net_rx_data/valid   word delivered by the router
//   tx_sent_count       words injected into the network (wraps)
//   rx_drop_count       network words dropped on a full RX FIFO (saturates)

module gpu_endpoint_ni #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0111,
  parameter logic [1:0] LOCAL_NODE = 2'd3,
  parameter int         GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] core_tx_data,
  input  logic [5:0]        core_tx_dest,
  input  logic              core_tx_valid,
  output logic              core_tx_ready,
  output logic [DWIDTH-1:0] core_rx_data,
  output logic              core_rx_valid,
  input  logic              core_rx_ready,
  output logic [DWIDTH-1:0] net_tx_data,
  output logic              net_tx_valid,
  output logic [5:0]        net_tx_dest,
  input  logic              net_busy,
  input  logic [DWIDTH-1:0] net_rx_data,
  input  logic              net_rx_valid,
  output logic [15:0]       tx_sent_count,
  output logic [7:0]        rx_drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = DWIDTH + 6;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [5:0]    LOOP_ADDR = {GROUP_ID, LOCAL_NODE};
  localparam logic [2:0]    GAP_LAST  = 3'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  // ---------------- TX FIFO: {dest, data} ----------------
  logic [TW-1:0]     r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]     r_tx_cnt;
  logic              r_tx_seen;
  logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [TW-1:0]     w_tx_head;
  logic [5:0]        w_head_dest;
  logic [DWIDTH-1:0] w_head_data;

  assign w_tx_full   = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty  = (r_tx_cnt == '0);
  assign w_tx_push   = core_tx_valid & ~w_tx_full;
  assign w_tx_head   = r_tx_mem[r_tx_rptr];
  assign w_head_dest = w_tx_head[TW-1:DWIDTH];
  assign w_head_data = w_tx_head[DWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {core_tx_dest, core_tx_data};
  end

  // r_tx_seen gives the head one cycle in the FIFO before the FSM acts on
  // it, which sets the write-to-issue and write-to-loopback latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
      r_tx_seen <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      r_tx_cnt  <= r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
      r_tx_seen <= ~w_tx_empty;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DWIDTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]     r_rx_cnt;
  logic              w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic              w_net_push, w_lb_push, w_drop;
  logic [DWIDTH-1:0] w_rx_wdata;

  // Fullness is judged before any same-cycle pop.
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_net_push = net_rx_valid & ~w_rx_full;
  // Loopback only fires when net_rx_valid is low, so network words win.
  assign w_rx_push  = w_net_push | w_lb_push;
  assign w_rx_wdata = net_rx_valid ? net_rx_data : w_head_data;
  assign w_rx_pop   = core_rx_ready & ~w_rx_empty;
  assign w_drop     = net_rx_valid & w_rx_full;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      r_rx_cnt <= r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
    end
  end

  // ---------------- Injection FSM ----------------
  logic [2:0]        r_gap_cnt;
  logic [DWIDTH-1:0] r_net_tx_data;
  logic [5:0]        r_net_tx_dest;
  logic [15:0]       r_tx_sent_cnt;
  logic [7:0]        r_rx_drop_cnt;
  logic              w_issue_load;

  always_comb begin
    w_next_state = r_state;
    w_tx_pop     = 1'b0;
    w_lb_push    = 1'b0;
    w_issue_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_tx_empty && r_tx_seen) begin
          if (w_head_dest == LOOP_ADDR) begin
            if (!w_rx_full && !net_rx_valid) begin
              w_tx_pop  = 1'b1;
              w_lb_push = 1'b1;
            end
          end else if (!net_busy) begin
            w_tx_pop     = 1'b1;
            w_issue_load = 1'b1;
            w_next_state = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_next_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_gap_cnt     <= '0;
      r_net_tx_data <= '0;
      r_net_tx_dest <= '0;
      r_tx_sent_cnt <= '0;
      r_rx_drop_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                  r_gap_cnt <= '0;
      if (w_issue_load) begin
        r_net_tx_data <= w_head_data;
        r_net_tx_dest <= w_head_dest;
      end
      if (r_state == S_ISSUE) r_tx_sent_cnt <= r_tx_sent_cnt + 16'd1;
      if (w_drop && r_rx_drop_cnt != 8'hFF) r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
    end
  end

  assign core_tx_ready = ~w_tx_full;
  assign core_rx_valid = ~w_rx_empty;
  assign core_rx_data  = r_rx_mem[r_rx_rptr];
  assign net_tx_valid  = (r_state == S_ISSUE);
  assign net_tx_data   = r_net_tx_data;
  assign net_tx_dest   = r_net_tx_dest;
  assign tx_sent_count = r_tx_sent_cnt;
  assign rx_drop_count = r_rx_drop_cnt;

endmodule

// File: tb/tb_gpu_endpoint_ni.sv
// tb/tb_gpu_endpoint_ni.sv - directed self-checking bench for gpu_endpoint_ni

module tb_gpu_endpoint_ni;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] core_tx_data;
  logic [5:0]  core_tx_dest;
  logic        core_tx_valid;
  logic        core_tx_ready;
  logic [15:0] core_rx_data;
  logic        core_rx_valid;
  logic        core_rx_ready;
  logic [15:0] net_tx_data;
  logic        net_tx_valid;
  logic [5:0]  net_tx_dest;
  logic        net_busy;
  logic [15:0] net_rx_data;
  logic        net_rx_valid;
  logic [15:0] tx_sent_count;
  logic [7:0]  rx_drop_count;

  int n_checks = 0;
  int n_errors = 0;

  gpu_endpoint_ni dut (
    .clk           (clk),
    .reset         (reset),
    .core_tx_data  (core_tx_data),
    .core_tx_dest  (core_tx_dest),
    .core_tx_valid (core_tx_valid),
    .core_tx_ready (core_tx_ready),
    .core_rx_data  (core_rx_data),
    .core_rx_valid (core_rx_valid),
    .core_rx_ready (core_rx_ready),
    .net_tx_data   (net_tx_data),
    .net_tx_valid  (net_tx_valid),
    .net_tx_dest   (net_tx_dest),
    .net_busy      (net_busy),
    .net_rx_data   (net_rx_data),
    .net_rx_valid  (net_rx_valid),
    .tx_sent_count (tx_sent_count),
    .rx_drop_count (rx_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int t_first, t_last, t_prev, gap_bad;
  int order_bad;
  int found;
  logic [15:0] exp_q [$];

  initial begin
    reset = 1'b0;
    core_tx_data = '0; core_tx_dest = '0; core_tx_valid = 1'b0;
    core_rx_ready = 1'b0; net_busy = 1'b0;
    net_rx_data = '0; net_rx_valid = 1'b0;
    tick(); tick();

    // reset state
    check("rst_tx_valid", 32'(net_tx_valid), 32'd0);
    check("rst_tx_data", 32'(net_tx_data), 32'd0);
    check("rst_tx_dest", 32'(net_tx_dest), 32'd0);
    check("rst_rx_valid", 32'(core_rx_valid), 32'd0);
    check("rst_tx_ready", 32'(core_tx_ready), 32'd1);
    check("rst_sent", 32'(tx_sent_count), 32'd0);
    check("rst_drop", 32'(rx_drop_count), 32'd0);
    reset = 1'b1;
    tick();

    // single word latency: valid only in the cycle after edge N+2
    core_tx_data = 16'hA5A5; core_tx_dest = 6'b010001; core_tx_valid = 1'b1;
    tick();
    core_tx_valid = 1'b0;
    check("lat_n0", 32'(net_tx_valid), 32'd0);
    tick();
    check("lat_n1", 32'(net_tx_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(net_tx_valid), 32'd1);
    check("lat_n2_data", 32'(net_tx_data), 32'hA5A5);
    check("lat_n2_dest", 32'(net_tx_dest), 32'h11);
    tick();
    check("lat_n3_valid", 32'(net_tx_valid), 32'd0);
    check("lat_sent", 32'(tx_sent_count), 32'd1);
    repeat (3) tick();

    // busy holds off, then three words issue in order 3 cycles apart
    net_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_tx_data = 16'h0B00 + 16'(i); core_tx_dest = 6'b000010; core_tx_valid = 1'b1;
      exp_q.push_back(16'h0B00 + 16'(i));
      tick();
    end
    core_tx_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (net_tx_valid) pulses++;
      tick();
    end
    check("busy_no_issue", 32'(pulses), 32'd0);
    net_busy = 1'b0;
    pulses = 0; t_prev = -100; gap_bad = 0; order_bad = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (net_tx_valid) begin
        if (pulses > 0 && c - t_prev != 3) gap_bad++;
        if (exp_q.size() == 0 || net_tx_data !== exp_q[0]) order_bad++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        t_prev = c;
        pulses++;
      end
    end
    check("busy_pulses", 32'(pulses), 32'd3);
    check("busy_spacing", 32'(gap_bad), 32'd0);
    check("busy_order", 32'(order_bad), 32'd0);
    check("busy_sent", 32'(tx_sent_count), 32'd4);

    // TX FIFO fills at 8 entries
    net_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      core_tx_data = 16'h0C00 + 16'(i); core_tx_dest = 6'b000001; core_tx_valid = 1'b1;
      #1;
      check($sformatf("full_ready_%0d", i), 32'(core_tx_ready), (i < 8) ? 32'd1 : 32'd0);
      tick();
    end
    core_tx_valid = 1'b0;
    net_busy = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (net_tx_valid) pulses++;
    end
    check("full_drain_pulses", 32'(pulses), 32'd8);
    check("full_sent", 32'(tx_sent_count), 32'd12);

    // loopback: appears on core_rx after edge N+2, never on the network
    core_tx_data = 16'hBEEF; core_tx_dest = 6'b011111; core_tx_valid = 1'b1;
    pulses = 0;
    tick();
    core_tx_valid = 1'b0;
    if (net_tx_valid) pulses++;
    tick();
    if (net_tx_valid) pulses++;
    check("lb_n1_rx_valid", 32'(core_rx_valid), 32'd0);
    tick();
    if (net_tx_valid) pulses++;
    check("lb_n2_rx_valid", 32'(core_rx_valid), 32'd1);
    check("lb_n2_rx_data", 32'(core_rx_data), 32'hBEEF);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (net_tx_valid) pulses++;
    end
    check("lb_no_net", 32'(pulses), 32'd0);
    check("lb_sent", 32'(tx_sent_count), 32'd12);
    core_rx_ready = 1'b1;
    tick();
    core_rx_ready = 1'b0;
    check("lb_popped", 32'(core_rx_valid), 32'd0);

    // RX overflow: 10 words into 8 entries, 2 dropped
    for (int i = 0; i < 10; i++) begin
      net_rx_data = 16'h1000 + 16'(i); net_rx_valid = 1'b1;
      tick();
    end
    net_rx_valid = 1'b0;
    check("rx_drop", 32'(rx_drop_count), 32'd2);
    core_rx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rx_drain_valid_%0d", k), 32'(core_rx_valid), 32'd1);
      check($sformatf("rx_drain_data_%0d", k), 32'(core_rx_data), 32'h1000 + k);
      tick();
    end
    core_rx_ready = 1'b0;
    check("rx_empty", 32'(core_rx_valid), 32'd0);

    // reset mid-ISSUE with 4 words still queued
    net_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_tx_data = 16'h0D00 + 16'(i); core_tx_dest = 6'b100000; core_tx_valid = 1'b1;
      tick();
    end
    core_tx_valid = 1'b0;
    net_busy = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (net_tx_valid) found = 1;
    end
    check("mid_issue_seen", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(net_tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(net_tx_data), 32'd0);
    check("mid_rst_tx_dest", 32'(net_tx_dest), 32'd0);
    check("mid_rst_sent", 32'(tx_sent_count), 32'd0);
    check("mid_rst_drop", 32'(rx_drop_count), 32'd0);
    check("mid_rst_tx_ready", 32'(core_tx_ready), 32'd1);
    tick(); tick();
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (net_tx_valid) pulses++;
    end
    check("post_rst_no_issue", 32'(pulses), 32'd0);
    check("post_rst_sent", 32'(tx_sent_count), 32'd0);
    check("post_rst_drop", 32'(rx_drop_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpu_endpoint_ni.md
# gpu_endpoint_ni

GPU-side network interface that sits between a GPU core and the `gpu_*` port of its group's leaf router. It buffers core transmit words and injects them into the router one word per issue slot, throttled by the router's crossbar-busy indication. It captures every word the router delivers into a receive buffer, with overflow drop-counting. Words addressed to the local GPU are looped back internally and never enter the network.

## Interface
Parameters:
- `DWIDTH`, 16, payload width.
- `FIFO_DEPTH`, 8, entries in each of the TX and RX FIFOs; power of two, ≥2.
- `GROUP_ID`, 4'b0111, this group's ID; upper 4 bits of the 6-bit address.
- `LOCAL_NODE`, 2'd3, this GPU's node index; lower 2 bits of the address.
- `GAP_CYCLES`, 1, idle cycles enforced after each network injection; range 0–7.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `core_tx_data` in DWIDTH: word from the core.
- `core_tx_dest` in 6: destination `{group[3:0], node[1:0]}`.
- `core_tx_valid` in 1: core offers a word.
- `core_tx_ready` out 1: TX FIFO not full.
- `core_rx_data` out DWIDTH: RX FIFO head (show-ahead).
- `core_rx_valid` out 1: RX FIFO not empty.
- `core_rx_ready` in 1: core pops the RX head.
- `net_tx_data` out DWIDTH: to router `gpu_in_data`.
- `net_tx_valid` out 1: to router `gpu_in_valid`.
- `net_tx_dest` out 6: to router `gpu_dest_addr`.
- `net_busy` in 1: router `crossbar_busy`.
- `net_rx_data` in DWIDTH: from router `gpu_out_data`.
- `net_rx_valid` in 1: from router `gpu_out_valid`.
- `tx_sent_count` out 16: words injected into the network; wraps.
- `rx_drop_count` out 8: network words dropped on a full RX FIFO; saturates at 255.

## Operation
- **TX FIFO:** stores `{dest, data}`. A write occurs on `core_tx_valid & core_tx_ready`.
- **Injection FSM:**
  - IDLE: if the TX FIFO is non-empty, evaluate the head.
    - Head dest == `{GROUP_ID, LOCAL_NODE}` (loopback): pop the head and write it to the RX FIFO. This requires the RX FIFO not full and `net_rx_valid` = 0; otherwise stay in IDLE. Loopback does not count in `tx_sent_count`.
    - Any other dest with `net_busy` = 0: pop the head and go to ISSUE.
    - Any other dest with `net_busy` = 1: stay in IDLE.
  - ISSUE (1 cycle): `net_tx_valid` = 1 with registered data and dest; increment `tx_sent_count`. Go to GAP if `GAP_CYCLES` > 0, else IDLE.
  - GAP: count `GAP_CYCLES` cycles, then return to IDLE.
- **Network output:** `net_tx_valid` is high only in ISSUE. `net_tx_data` and `net_tx_dest` hold their last value otherwise.
- **RX capture:**
  - `net_rx_valid` = 1 with the RX FIFO not full: write the word.
  - `net_rx_valid` = 1 with the RX FIFO full: drop the word and increment `rx_drop_count` (saturating).
  - A pop in the same cycle does not free space for that cycle's write. Fullness is evaluated before the pop.
- **RX arbitration:** network words have priority over loopback words for the single RX write port.
- **FIFO boundaries:**
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Pop on empty and push on full are ignored.

## Timing
- **Reset values:** on `reset` = 0 all state clears asynchronously.
  - FSM = IDLE; FIFOs empty.
  - `net_tx_valid`, `net_tx_data`, `net_tx_dest` = 0.
  - `core_rx_valid` = 0; `core_tx_ready` = 1.
  - Both counters = 0.
  - A word in flight is lost; no partial ISSUE occurs after release.
- **TX latency:** a word written at edge N (empty FIFO, IDLE, `net_busy` = 0) gives `net_tx_valid` = 1 in the cycle after edge N+2.
- **Injection rate:** back-to-back injections are `GAP_CYCLES` + 2 cycles apart.
- **RX latency:** a network word sampled at edge N gives `core_rx_valid` = 1 after edge N.
- **Loopback latency:** a loopback word written to the TX FIFO at edge N appears on `core_rx_*` after edge N+2.
- **`core_tx_ready`:** combinational from the FIFO count (not full).

## Test plan
- Reset, then write dest 6'b010001, data 16'hA5A5, `net_busy` = 0 -> `net_tx_valid` pulses exactly 1 cycle after edge N+2 with that data and dest; `tx_sent_count` = 1.
- Hold `net_busy` = 1 and write 3 words -> no `net_tx_valid`. Release busy -> words issue in order, 3 cycles apart (`GAP_CYCLES` = 1).
- Write 9 words with `net_busy` = 1 -> `core_tx_ready` drops after the 8th word; the 9th is not accepted.
- Write dest 6'b011111 (loopback) -> `net_tx_valid` never asserts; `core_rx_data` equals the word after 2 edges; `tx_sent_count` unchanged.
- Drive 10 consecutive `net_rx_valid` words with `core_rx_ready` = 0 -> first 8 are buffered; `rx_drop_count` = 2. Then raise `core_rx_ready` -> the 8 words drain in order.
- Assert `reset` = 0 mid-ISSUE with 4 words queued -> all outputs zero immediately. After release nothing is injected and both counters read 0.
